// File: rtl/dot_layer.sv
// rtl/dot_layer.sv - fully-connected dot-product engine: GROUPS vectors x OUT_CH saturating dot products.
// Build option: define DOT_LAYER_RELU_EN to clamp negative results to zero before they reach q.
module dot_layer #(
    parameter int DATA_LEN   = 16,
    parameter int FRAC       = 8,
    parameter int VEC_LEN    = 288,
    parameter int WORD_ELEMS = 9,
    parameter int OUT_CH     = 32,
    parameter int GROUPS     = 12,
    parameter int ADDR_W     = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                valid,
    output logic [ADDR_W-1:0]                   addr,
    input  logic [WORD_ELEMS*DATA_LEN-1:0]      d,
    output logic [$clog2(VEC_LEN)-1:0]          w_addr,
    input  logic [OUT_CH*DATA_LEN-1:0]          w_data,
    output logic [GROUPS*OUT_CH*DATA_LEN-1:0]   q
);

    localparam int WORDS = VEC_LEN / WORD_ELEMS;
    localparam int KW    = $clog2(VEC_LEN);
    localparam int FW    = $clog2(WORDS + 1);
    localparam int MW    = $clog2(VEC_LEN + 1);
    localparam int GW    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int ACC_W = 2 * DATA_LEN + KW;

    localparam logic [FW-1:0] F_LAST = FW'(WORDS);
    localparam logic [MW-1:0] M_LAST = MW'(VEC_LEN);
    localparam logic [MW-1:0] M_ONE  = MW'(1);
    localparam logic [KW-1:0] K_LAST = KW'(VEC_LEN - 1);
    localparam logic [KW-1:0] K_STEP = KW'(WORD_ELEMS);
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_STORE, S_DONE} state_t;
    state_t state_q, state_d;

    logic [FW-1:0] fcnt;
    logic [MW-1:0] mcnt;
    logic [GW-1:0] g;
    logic [KW-1:0] wbase;
    logic [KW-1:0] kq;

    logic signed [DATA_LEN-1:0]   vbuf     [VEC_LEN];
    logic signed [ACC_W-1:0]      acc      [OUT_CH];
    logic signed [2*DATA_LEN-1:0] prod     [OUT_CH];
    logic signed [ACC_W-1:0]      prod_ext [OUT_CH];
    logic signed [ACC_W-1:0]      shifted  [OUT_CH];
    logic signed [DATA_LEN-1:0]   res      [OUT_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_FETCH;
            S_FETCH:        if (fcnt == F_LAST) state_d = S_MAC;
            S_MAC:          if (mcnt == M_LAST) state_d = S_STORE;
            S_STORE:        state_d = (g == G_LAST) ? S_DONE : S_FETCH;
            default:        state_d = S_IDLE;
        endcase
    end

    // kq trails w_addr by one cycle, matching the weight RAM latency.
    always_comb begin
        for (int c = 0; c < OUT_CH; c++) begin
            prod[c]     = vbuf[kq] * $signed(w_data[c*DATA_LEN +: DATA_LEN]);
            prod_ext[c] = {{(ACC_W-2*DATA_LEN){prod[c][2*DATA_LEN-1]}}, prod[c]};
            shifted[c]  = acc[c] >>> FRAC;
            if (shifted[c] > SAT_MAX)
                res[c] = SAT_MAX[DATA_LEN-1:0];
            else if (shifted[c] < SAT_MIN)
                res[c] = SAT_MIN[DATA_LEN-1:0];
            else
                res[c] = shifted[c][DATA_LEN-1:0];
`ifdef DOT_LAYER_RELU_EN
            if (res[c][DATA_LEN-1]) res[c] = '0;
`endif
        end
    end

    // Feature words land one cycle after their address, so fcnt==0 has nothing to capture.
    always_ff @(posedge clk) begin
        if (state_q == S_FETCH && fcnt != '0) begin
            for (int e = 0; e < WORD_ELEMS; e++)
                vbuf[wbase + KW'(e)] <= d[e*DATA_LEN +: DATA_LEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            valid  <= 1'b0;
            addr   <= '0;
            w_addr <= '0;
            q      <= '0;
            fcnt   <= '0;
            mcnt   <= '0;
            g      <= '0;
            wbase  <= '0;
            kq     <= '0;
            for (int c = 0; c < OUT_CH; c++) acc[c] <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        valid  <= 1'b0;
                        g      <= '0;
                        addr   <= '0;
                        w_addr <= '0;
                        fcnt   <= '0;
                        mcnt   <= '0;
                        wbase  <= '0;
                    end
                end
                S_FETCH: begin
                    if (fcnt != '0) wbase <= wbase + K_STEP;
                    if (fcnt == F_LAST) begin
                        fcnt   <= '0;
                        mcnt   <= '0;
                        w_addr <= '0;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                        addr <= addr + 1'b1;
                    end
                end
                S_MAC: begin
                    kq   <= w_addr;
                    mcnt <= mcnt + 1'b1;
                    if (w_addr != K_LAST) w_addr <= w_addr + 1'b1;
                    if (mcnt != '0) begin
                        for (int c = 0; c < OUT_CH; c++)
                            acc[c] <= (mcnt == M_ONE) ? prod_ext[c] : acc[c] + prod_ext[c];
                    end
                end
                S_STORE: begin
                    for (int gi = 0; gi < GROUPS; gi++)
                        for (int c = 0; c < OUT_CH; c++)
                            if (g == GW'(gi))
                                q[(GROUPS*c+gi)*DATA_LEN +: DATA_LEN] <= res[c];
                    w_addr <= '0;
                    mcnt   <= '0;
                    fcnt   <= '0;
                    wbase  <= '0;
                    if (g == G_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        valid <= 1'b1;
                    end else begin
                        g <= g + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
